// File: rtl/sccb_target_if.sv
// SCCB target bus lines plus register-port signals.
// The slave modport is the target side; master is the bus/register model side.
interface sccb_target_if;
  logic       sccb_clk_in;
  logic       sccb_data_in;
  logic       sccb_data_out;
  logic       sccb_data_en;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  sccb_clk_in,
    input  sccb_data_in,
    input  reg_rdata,
    output sccb_data_out,
    output sccb_data_en,
    output reg_wr,
    output reg_addr,
    output reg_wdata,
    output busy
  );

  modport master (
    output sccb_clk_in,
    output sccb_data_in,
    output reg_rdata,
    input  sccb_data_out,
    input  sccb_data_en,
    input  reg_wr,
    input  reg_addr,
    input  reg_wdata,
    input  busy
  );
endinterface

// File: rtl/sccb_target.sv
// Oversampled SCCB/I2C-style target decoding ID, sub-address,
// write data and read requests onto a simple register port.
module sccb_target #(
  parameter logic [6:0] DEV_ID   = 7'h30,
  parameter bit         ACK_EN   = 1'b1,
  parameter bit         AUTO_INC = 1'b1
) (
  input logic          clk,
  input logic          rst,
  sccb_target_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sy, sda_sy;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;
  logic       rise, fall, start, stop;

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [7:0] sh_q, sh_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] wdata_q, wdata_n;
  logic [7:0] byte_in;
  logic [7:0] addr_inc;
  logic       rw_q, rw_n;
  logic       ack_q, ack_n;
  logic       en_q, en_n;
  logic       out_q, out_n;
  logic       wr_q, wr_n;
  logic       busy_q, busy_n;

  // Idle bus is high, so sync and history flops reset high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], bus.sccb_clk_in};
      sda_sy <= {sda_sy[0], bus.sccb_data_in};
      scl_d  <= scl_sy[1];
      sda_d  <= sda_sy[1];
    end
  end

  assign scl_s = scl_sy[1];
  assign sda_s = sda_sy[1];
  assign rise  = scl_s & ~scl_d;
  assign fall  = ~scl_s & scl_d;
  // SCL must be high in both samples so a joint change counts as data.
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_in  = {sh_q[6:0], sda_s};
  assign addr_inc = AUTO_INC ? addr_q + 8'd1 : addr_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sh_n    = sh_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rw_n    = rw_q;
    ack_n   = ack_q;
    en_n    = en_q;
    out_n   = out_q;
    wr_n    = 1'b0;
    busy_n  = busy_q;
    if (start) begin
      state_n = ID;
      cnt_n   = 4'd0;
      busy_n  = 1'b1;
      en_n    = 1'b0;
      out_n   = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      en_n    = 1'b0;
      out_n   = 1'b1;
    end else begin
      unique case (state_q)
        ID: begin
          if (rise) begin
            sh_n  = byte_in;
            cnt_n = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            cnt_n = 4'd0;
            if (sh_q[7:1] == DEV_ID) begin
              state_n = ID_ACK;
              rw_n    = sh_q[0];
              en_n    = ACK_EN;
              out_n   = 1'b0;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ID_ACK: begin
          if (fall) begin
            cnt_n = 4'd0;
            if (rw_q) begin
              state_n = RDATA;
              sh_n    = bus.reg_rdata;
              en_n    = 1'b1;
              out_n   = bus.reg_rdata[7];
            end else begin
              state_n = SUB;
              en_n    = 1'b0;
              out_n   = 1'b1;
            end
          end
        end
        SUB, WDATA: begin
          if (rise) begin
            sh_n  = byte_in;
            cnt_n = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == SUB) begin
                addr_n = byte_in;
              end else begin
                wdata_n = byte_in;
                wr_n    = 1'b1;
              end
            end
          end else if (fall && cnt_q == 4'd8) begin
            state_n = (state_q == SUB) ? SUB_ACK : WDATA_ACK;
            cnt_n   = 4'd0;
            en_n    = ACK_EN;
            out_n   = 1'b0;
          end
        end
        SUB_ACK, WDATA_ACK: begin
          if (fall) begin
            state_n = WDATA;
            en_n    = 1'b0;
            out_n   = 1'b1;
            if (state_q == WDATA_ACK) addr_n = addr_inc;
          end
        end
        RDATA: begin
          if (fall) begin
            if (cnt_q == 4'd7) begin
              state_n = RDATA_ACK;
              cnt_n   = 4'd0;
              ack_n   = 1'b0;
              en_n    = 1'b0;
              out_n   = 1'b1;
            end else begin
              sh_n  = {sh_q[6:0], 1'b0};
              out_n = sh_q[6];
              cnt_n = cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (rise) begin
            if (sda_s) begin
              state_n = WAIT_STOP;
            end else begin
              ack_n  = 1'b1;
              addr_n = addr_inc;
            end
          end else if (fall && ack_q) begin
            // Reload after the pointer moved so reg_rdata is current.
            state_n = RDATA;
            ack_n   = 1'b0;
            sh_n    = bus.reg_rdata;
            en_n    = 1'b1;
            out_n   = bus.reg_rdata[7];
            cnt_n   = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'h00;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      out_q   <= 1'b1;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rw_q    <= rw_n;
      ack_q   <= ack_n;
      en_q    <= en_n;
      out_q   <= out_n;
      wr_q    <= wr_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.sccb_data_en  = en_q;
  assign bus.sccb_data_out = out_q;
  assign bus.reg_wr        = wr_q;
  assign bus.reg_addr      = addr_q;
  assign bus.reg_wdata     = wdata_q;
  assign bus.busy          = busy_q;

endmodule
